deslocador_serial: RTL and testbench
====================================

# deslocador_serial

Multi-cycle variable-amount shifter for the MIC datapath, complementing the fixed single-cycle shifter on the ALU output. Executes IJVM-style ISHL/ISHR/IUSHR and rotate-right by an arbitrary 0–31 bit amount, one bit position per clock. Sits beside the ALU/shifter path; the control store starts it with a one-cycle `start` and stalls the microsequencer until `done`.

## Interface
- `WIDTH`, default 32, operand/result width.
- `SHAMT_W`, default 5, shift-amount width (log2 WIDTH).
- `clk` in 1, single clock; all state updates on its rising edge.
- `rst_n` in 1, asynchronous active-low reset.
- `start` in 1, request; sampled only in IDLE.
- `op` in 2, operation: 0 SLL, 1 SRL, 2 SRA, 3 ROR.
- `shamt` in SHAMT_W, shift amount, unsigned.
- `E` in WIDTH, signed operand.
- `R` out WIDTH, signed result register.
- `busy` out 1, high in any state other than IDLE.
- `done` out 1, one-cycle pulse: R valid and final.

## Operation
- Reset (async, rst_n low): state IDLE, R=0, busy=0, done=0, internal count=0. Reset mid-operation abandons the shift; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE: on edge with start=1, load R←E, latch op, count←shamt; go to SHIFT if shamt≠0, else DONE. start=0: stay, R holds.
- SHIFT: each edge applies one 1-bit step to R per latched op, count←count−1; when count==1 at the edge (last step), go to DONE.
  - SLL: R←{R[W-2:0],0}. SRL: R←{0,R[W-1:1]}. SRA: R←{R[W-1],R[W-1:1]}. ROR: R←{R[0],R[W-1:1]}.
- DONE: done=1 for exactly this cycle; next edge → IDLE. R unchanged.
- start while busy (SHIFT or DONE) is ignored, not queued. Inputs op/shamt/E changing while busy have no effect.
- R holds its final value in IDLE until the next accepted start.
- Result equals E shifted by shamt in full-width arithmetic: SRA of negative by 31 gives all ones; SLL by 31 leaves only E[0] in MSB; ROR by 0 or by WIDTH-multiples is identity.

## Timing
- start accepted at edge T0. shamt=n: steps at edges T1..Tn; done high in the cycle following Tn (the cycle after edge Tn), i.e. latency n+1 cycles; shamt=0 → done in the cycle after T0.
- busy rises in the cycle after T0 and falls in the cycle after done.
- Back-to-back: earliest next acceptance is the edge ending the first IDLE cycle after DONE; throughput one operation per n+2 cycles.
- done and busy are registered state decodes; no combinational input→output path.

## Structure
- Shared package `mic_pkg`: enum `desloc_op_t` {DESL_SLL=0, DESL_SRL=1, DESL_SRA=2, DESL_ROR=3}; state enum `desloc_est_t` {IDLE, SHIFT, DONE}.
- One combinational sub-module `deslocador_passo` (1-bit step per op, WIDTH parameter); top holds FSM, counter, R register.

## Test plan
- Reset: drive rst_n low mid-SHIFT (SRA, shamt=20) → R=0, busy=0, done=0 immediately; no done pulse afterward.
- SRA: E=0x8000_00F0, shamt=4 → done in cycle 5 after start, R=0xF800_000F; SRA shamt=31 on 0x8000_0000 → R=0xFFFF_FFFF.
- SRL and SLL: E=0x8000_00F0 SRL 4 → 0x0800_000F; E=0x0000_00FF SLL 8 → 0x0000_FF00, done at cycle 9.
- ROR: E=0x0000_0001, shamt=1 → 0x8000_0000; shamt=0 → R=E, done in cycle 1.
- Handshake: start held high continuously with alternating operands → each op completes, start ignored while busy, next accepted only from IDLE; done exactly one cycle wide each time.
- Random: 1000 random E/op/shamt compared against reference-model shift; latency checked as shamt+1.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared MIC datapath types: serial shifter operations and FSM states.
package mic_pkg;

    typedef enum logic [1:0] {
        DESL_SLL = 2'd0,
        DESL_SRL = 2'd1,
        DESL_SRA = 2'd2,
        DESL_ROR = 2'd3
    } desloc_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } desloc_est_t;

endpackage

// File: rtl/deslocador_passo.sv
// One-bit shift/rotate step; the serial shifter applies it once per clock.
module deslocador_passo
    import mic_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  desloc_op_t       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Single-position move selected by the latched operation
    always_comb begin
        dout = din;
        unique case (op)
            DESL_SLL: dout = {din[WIDTH-2:0], 1'b0};
            DESL_SRL: dout = {1'b0, din[WIDTH-1:1]};
            DESL_SRA: dout = {din[WIDTH-1], din[WIDTH-1:1]};
            DESL_ROR: dout = {din[0], din[WIDTH-1:1]};
            default:  dout = din;
        endcase
    end

endmodule

// File: rtl/deslocador_serial.sv
// Multi-cycle variable-amount shifter: one bit position per clock, done pulse at the end.
module deslocador_serial
    import mic_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   E,
    output logic [WIDTH-1:0]   R,
    output logic               busy,
    output logic               done
);

    desloc_est_t        estado_q, estado_d;
    desloc_op_t         op_q, op_d;
    logic [SHAMT_W-1:0] conta_q, conta_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]   passo;

    deslocador_passo #(
        .WIDTH (WIDTH)
    ) u_passo (
        .op   (op_q),
        .din  (r_q),
        .dout (passo)
    );

    // Next-state, counter and result update; inputs only matter when accepted in IDLE
    always_comb begin
        estado_d = estado_q;
        op_d     = op_q;
        conta_d  = conta_q;
        r_d      = r_q;
        unique case (estado_q)
            IDLE: begin
                if (start) begin
                    r_d      = E;
                    op_d     = desloc_op_t'(op);
                    conta_d  = shamt;
                    estado_d = (shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                r_d     = passo;
                conta_d = conta_q - SHAMT_W'(1);
                if (conta_q == SHAMT_W'(1)) begin
                    estado_d = DONE;
                end
            end
            DONE: begin
                estado_d = IDLE;
            end
            default: estado_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset that abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= IDLE;
            op_q     <= DESL_SLL;
            conta_q  <= '0;
            r_q      <= '0;
        end else begin
            estado_q <= estado_d;
            op_q     <= op_d;
            conta_q  <= conta_d;
            r_q      <= r_d;
        end
    end

    // Outputs are pure decodes of registered state
    always_comb begin
        R    = r_q;
        busy = (estado_q != IDLE);
        done = (estado_q == DONE);
    end

endmodule

// File: tb/tb_deslocador_serial.sv
// Directed-vector and random check of deslocador_serial results, latency and handshake.
module tb_deslocador_serial;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [1:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   E;
    logic [WIDTH-1:0]   R;
    logic               busy;
    logic               done;

    int n_vec;
    int n_err;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  shamt;
        logic [31:0] e;
        logic [31:0] r_exp;
        int          lat_exp;
    } vec_t;

    deslocador_serial #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .shamt (shamt),
        .E     (E),
        .R     (R),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Full-width arithmetic reference, independent of the step-by-step datapath
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [4:0] s,
                                              input logic [31:0] e);
        int unsigned su;
        su = s;
        case (o)
            2'd0: return e << su;
            2'd1: return e >> su;
            2'd2: return $unsigned($signed(e) >>> su);
            default: return (su == 0) ? e : ((e >> su) | (e << (32 - su)));
        endcase
    endfunction

    // Starts from an IDLE cycle sampled #1 after an edge; returns result and latency
    task automatic run_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] e,
                          output logic [31:0] r, output int lat);
        op    = o;
        shamt = s;
        E     = e;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        E     = ~e;
        op    = ~o;
        shamt = ~s;
        lat   = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = R;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: done never rose, lat %0d", lat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vecs[12];
        logic [31:0] r;
        int          lat;
        int          seen;

        n_vec = 0;
        n_err = 0;
        start = 1'b0;
        op    = '0;
        shamt = '0;
        E     = '0;
        rst_n = 1'b0;

        vecs[0]  = '{2'd2, 5'd4,  32'h8000_00F0, 32'hF800_000F, 5};
        vecs[1]  = '{2'd2, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 32};
        vecs[2]  = '{2'd1, 5'd4,  32'h8000_00F0, 32'h0800_000F, 5};
        vecs[3]  = '{2'd0, 5'd8,  32'h0000_00FF, 32'h0000_FF00, 9};
        vecs[4]  = '{2'd3, 5'd1,  32'h0000_0001, 32'h8000_0000, 2};
        vecs[5]  = '{2'd3, 5'd0,  32'h1234_5678, 32'h1234_5678, 1};
        vecs[6]  = '{2'd0, 5'd31, 32'h0000_0003, 32'h8000_0000, 32};
        vecs[7]  = '{2'd3, 5'd31, 32'h0000_0001, 32'h0000_0002, 32};
        vecs[8]  = '{2'd1, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 32};
        vecs[9]  = '{2'd2, 5'd4,  32'h7000_0010, 32'h0700_0001, 5};
        vecs[10] = '{2'd2, 5'd0,  32'h8000_0000, 32'h8000_0000, 1};
        vecs[11] = '{2'd0, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_R", R, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].shamt, vecs[i].e, r, lat);
            chk($sformatf("vec%0d_R", i), r, vecs[i].r_exp);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat_exp);
            chk($sformatf("vec%0d_idle", i), {30'b0, busy, done}, 32'h0);
            chk($sformatf("vec%0d_hold", i), R, vecs[i].r_exp);
        end

        // Reset in the middle of SRA by 20: immediate clear, no later done
        op    = 2'd2;
        shamt = 5'd20;
        E     = 32'h8000_00F0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midshift_busy", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_R", R, 32'h0);
        chk("async_busy", {31'b0, busy}, 32'h0);
        chk("async_done", {31'b0, done}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        chk("no_done_after_reset", seen, 0);

        // Start held high: changes while busy are ignored, re-accept only from IDLE
        op    = 2'd0;
        shamt = 5'd3;
        E     = 32'h0000_0011;
        start = 1'b1;
        @(posedge clk);
        #1;
        op    = 2'd1;
        shamt = 5'd2;
        E     = 32'hF000_0000;
        lat   = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hs_a_R", R, 32'h0000_0088);
        chk("hs_a_lat", lat, 4);
        @(posedge clk);
        #1;
        chk("hs_a_pulse", {30'b0, busy, done}, 32'h0);
        @(posedge clk);
        #1;
        chk("hs_b_accept", {30'b0, busy, done}, 32'h2);
        op    = 2'd3;
        shamt = 5'd7;
        E     = 32'h1111_1111;
        lat   = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk("hs_b_R", R, 32'h3C00_0000);
        chk("hs_b_lat", lat, 3);
        @(posedge clk);
        #1;
        chk("hs_b_pulse", {30'b0, busy, done}, 32'h0);

        // Random operands against the full-width reference
        for (int i = 0; i < 1000; i++) begin
            logic [1:0]  ro;
            logic [4:0]  rs;
            logic [31:0] re;
            ro = 2'($urandom_range(0, 3));
            rs = 5'($urandom_range(0, 31));
            re = $urandom;
            run_op(ro, rs, re, r, lat);
            chk($sformatf("rnd%0d_R op%0d sh%0d e%h", i, ro, rs, re), r, ref_shift(ro, rs, re));
            chk($sformatf("rnd%0d_lat", i), lat, 32'(rs) + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
